// File: rtl/resp_router.sv
// Return-path router: steers in-order memory responses to the fetch (port 0)
// or data (port 1) requester using a FIFO of request tags.
module resp_router #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_fire,
    input  logic                     req_sel,
    output logic                     tag_full,
    output logic [$clog2(DEPTH):0]   outstanding,
    input  logic                     resp_valid,
    input  logic [DATA_W-1:0]        resp_data,
    output logic                     resp_ready,
    output logic                     out0_valid,
    output logic [DATA_W-1:0]        out0_data,
    input  logic                     out0_ready,
    output logic                     out1_valid,
    output logic [DATA_W-1:0]        out1_data,
    input  logic                     out1_ready,
    output logic                     err_unexpected
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic              tag_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              err_q;
    logic [1:0]        out_valid_q;
    logic [DATA_W-1:0] out_data_q [2];

    logic              head_sel;
    logic              push, accept;
    logic [1:0]        out_ready, slot_free, load;

    assign head_sel   = tag_q[rd_ptr_q];
    assign tag_full   = (count_q == CW'(DEPTH));
    assign push       = req_fire & ~tag_full;
    assign out_ready  = {out1_ready, out0_ready};
    assign slot_free  = ~out_valid_q | out_ready;
    // Only the head tag decides readiness, so a stalled port blocks everything behind it.
    assign resp_ready = (count_q != '0) & slot_free[head_sel];
    assign accept     = resp_valid & resp_ready;
    assign load       = {accept & head_sel, accept & ~head_sel};

    always_comb begin
        count_d = count_q;
        case ({push, accept})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push) begin
                tag_q[wr_ptr_q] <= req_sel;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (accept) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
            if (resp_valid && count_q == '0) begin
                err_q <= 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        // A new load wins over a drain, keeping one response per cycle per port.
        always_ff @(posedge clk) begin
            if (rst) begin
                out_valid_q[gi] <= 1'b0;
                out_data_q[gi]  <= '0;
            end else if (load[gi]) begin
                out_valid_q[gi] <= 1'b1;
                out_data_q[gi]  <= resp_data;
            end else if (out_ready[gi]) begin
                out_valid_q[gi] <= 1'b0;
            end
        end
    end

    assign outstanding    = count_q;
    assign out0_valid     = out_valid_q[0];
    assign out1_valid     = out_valid_q[1];
    assign out0_data      = out_data_q[0];
    assign out1_data      = out_data_q[1];
    assign err_unexpected = err_q;
endmodule

// File: tb/tb_resp_router.sv
// Randomized scoreboard bench for resp_router: a queue-based model predicts
// routing, occupancy and flags; a monitor checks every delivered response.
module tb_resp_router;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_fire = 1'b0, req_sel = 1'b0;
    logic          tag_full;
    logic [CW-1:0] outstanding;
    logic          resp_valid = 1'b0;
    logic [DW-1:0] resp_data = '0;
    logic          resp_ready;
    logic          out0_valid, out1_valid;
    logic [DW-1:0] out0_data, out1_data;
    logic          out0_ready = 1'b0, out1_ready = 1'b0;
    logic          err_unexpected;

    always #5 clk = ~clk;

    resp_router #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_fire(req_fire), .req_sel(req_sel),
        .tag_full(tag_full), .outstanding(outstanding),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready),
        .out0_valid(out0_valid), .out0_data(out0_data), .out0_ready(out0_ready),
        .out1_valid(out1_valid), .out1_data(out1_data), .out1_ready(out1_ready),
        .err_unexpected(err_unexpected)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: pending requester tags, per-port occupancy, sticky error.
    bit            m_tags[$];
    int            m_occ[2];
    bit            m_err;
    bit            m_after_rst;
    logic [DW-1:0] exp_q0[$];
    logic [DW-1:0] exp_q1[$];
    bit            started = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int rst_p, input int fire_p, input int valid_p,
                        input int rdy0_p, input int rdy1_p);
        bit m_rdy, acc, h;
        int sz;
        @(posedge clk);
        #1;
        rst        = ($urandom_range(0, 999) < rst_p);
        req_fire   = ($urandom_range(0, 99) < fire_p);
        req_sel    = $urandom_range(0, 1);
        resp_valid = ($urandom_range(0, 99) < valid_p);
        resp_data  = $urandom;
        out0_ready = ($urandom_range(0, 99) < rdy0_p);
        out1_ready = ($urandom_range(0, 99) < rdy1_p);
        @(negedge clk);
        sz = m_tags.size();
        m_rdy = 1'b0;
        if (sz > 0) begin
            h = m_tags[0];
            m_rdy = (m_occ[h] == 0) || (h ? out1_ready : out0_ready);
        end
        check("resp_ready", resp_ready, m_rdy);
        check("outstanding", outstanding, sz);
        check("tag_full", tag_full, sz == DEPTH);
        check("err_unexpected", err_unexpected, m_err);
        check("out0_valid", out0_valid, m_occ[0] != 0);
        check("out1_valid", out1_valid, m_occ[1] != 0);
        if (m_after_rst) begin
            check("out0_data_rst", out0_data, 0);
            check("out1_data_rst", out1_data, 0);
        end
        if (rst) begin
            m_tags.delete();
            exp_q0.delete();
            exp_q1.delete();
            m_occ[0] = 0;
            m_occ[1] = 0;
            m_err = 1'b0;
            m_after_rst = 1'b1;
        end else begin
            m_after_rst = 1'b0;
            acc = resp_valid & m_rdy;
            if (m_occ[0] != 0 && out0_ready) m_occ[0] = 0;
            if (m_occ[1] != 0 && out1_ready) m_occ[1] = 0;
            if (acc) begin
                h = m_tags.pop_front();
                m_occ[h] = 1;
                if (h) exp_q1.push_back(resp_data);
                else   exp_q0.push_back(resp_data);
            end
            if (req_fire && sz < DEPTH) m_tags.push_back(req_sel);
            if (resp_valid && sz == 0) m_err = 1'b1;
        end
    endtask

    // Monitor: every presented response must match the oldest expectation for its port.
    always @(negedge clk) begin
        if (started && !rst) begin
            if (out0_valid) begin
                if (exp_q0.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL port0_data: got %0h expected none", out0_data);
                end else begin
                    check("port0_data", out0_data, exp_q0[0]);
                    if (out0_ready) begin
                        $display("port0 delivered %08h", out0_data);
                        void'(exp_q0.pop_front());
                    end
                end
            end
            if (out1_valid) begin
                if (exp_q1.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL port1_data: got %0h expected none", out1_data);
                end else begin
                    check("port1_data", out1_data, exp_q1[0]);
                    if (out1_ready) begin
                        $display("port1 delivered %08h", out1_data);
                        void'(exp_q1.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int cfg [5][5];
        cfg = '{'{0, 60, 60, 100, 100},
                '{0, 90, 10, 100, 100},
                '{0, 70, 90, 30, 80},
                '{0, 50, 80, 100, 20},
                '{8, 80, 80, 90, 90}};
        m_occ[0] = 0;
        m_occ[1] = 0;
        m_err = 1'b0;
        m_after_rst = 1'b1;
        @(posedge clk);
        started = 1'b1;
        // Reset held two cycles while request and response activity is driven.
        for (int i = 0; i < 2; i++) step(1000, 100, 100, 100, 100);
        for (int p = 0; p < 5; p++)
            for (int c = 0; c < 400; c++)
                step(cfg[p][0], cfg[p][1], cfg[p][2], cfg[p][3], cfg[p][4]);
        // Drain with no new traffic beyond what is still tagged.
        for (int c = 0; c < 20; c++) step(0, 0, 100, 100, 100);
        check("final_port0_queue", exp_q0.size(), 0);
        check("final_port1_queue", exp_q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
